// File: rtl/multicycle_adder_subtractor_if.sv
// multicycle_adder_subtractor_if: start/busy/done operand and result bus for the multicycle adder-subtractor
interface multicycle_adder_subtractor_if #(parameter int WIDTH = 16);
  logic start, sub, CI, busy, done, CO, OV;
  logic [WIDTH-1:0] A, B, S;
  modport master(output start, sub, A, B, CI, input busy, done, S, CO, OV);
  modport slave(input start, sub, A, B, CI, output busy, done, S, CO, OV);
endinterface

// File: rtl/multicycle_adder_subtractor.sv
// multicycle_adder_subtractor: WIDTH-bit add/subtract, DIGIT bits per cycle, carry chained through a register
module multicycle_adder_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic clk,
  input logic rst,
  multicycle_adder_subtractor_if.slave bus
);
  localparam int N = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_s;
  logic [CW-1:0] r_cnt;
  logic r_c, r_busy, r_done, r_co, r_ov;
  logic [DIGIT-1:0] w_da, w_db;
  logic [DIGIT:0] w_sum;
  logic [WIDTH+DIGIT-1:0] w_cat;
  logic w_last, w_cmsb;
  assign w_da = r_a[int'(r_cnt) * DIGIT +: DIGIT];
  assign w_db = r_b[int'(r_cnt) * DIGIT +: DIGIT];
  assign w_sum = {1'b0, w_da} + {1'b0, w_db} + {{DIGIT{1'b0}}, r_c};
  // new digit enters at the top; after N shifts the result is aligned
  assign w_cat = {w_sum[DIGIT-1:0], r_acc};
  assign w_cmsb = w_da[DIGIT-1] ^ w_db[DIGIT-1] ^ w_sum[DIGIT-1];
  assign w_last = r_cnt == CW'(N - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_a <= '0;
      r_b <= '0;
      r_acc <= '0;
      r_s <= '0;
      r_cnt <= '0;
      r_c <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_co <= 1'b0;
      r_ov <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == RUN) begin
        r_acc <= w_cat[WIDTH+DIGIT-1:DIGIT];
        r_c <= w_sum[DIGIT];
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_s <= w_cat[WIDTH+DIGIT-1:DIGIT];
          r_co <= w_sum[DIGIT];
          r_ov <= w_cmsb ^ w_sum[DIGIT];
          r_done <= 1'b1;
          r_busy <= 1'b0;
          r_state <= DONE;
        end
      end else if (bus.start) begin
        r_a <= bus.A;
        r_b <= bus.B ^ {WIDTH{bus.sub}};
        r_c <= bus.CI ^ bus.sub;
        r_cnt <= '0;
        r_busy <= 1'b1;
        r_state <= RUN;
      end else
        r_state <= IDLE;
    end
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.S = r_s;
  assign bus.CO = r_co;
  assign bus.OV = r_ov;
endmodule

// File: tb/tb_multicycle_adder_subtractor.sv
// tb_multicycle_adder_subtractor: scoreboard bench driving DIGIT=1, 4 and 16 instances side by side
module tb_multicycle_adder_subtractor;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, failures = 0;
  logic [17:0] q1[$], q4[$], q16[$];
  always #5 clk = ~clk;
  multicycle_adder_subtractor_if #(.WIDTH(16)) if1(), if4(), if16();
  multicycle_adder_subtractor #(.WIDTH(16), .DIGIT(1)) u1(.clk(clk), .rst(rst), .bus(if1));
  multicycle_adder_subtractor #(.WIDTH(16), .DIGIT(4)) u4(.clk(clk), .rst(rst), .bus(if4));
  multicycle_adder_subtractor #(.WIDTH(16), .DIGIT(16)) u16(.clk(clk), .rst(rst), .bus(if16));

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  // {CO, OV, S} reference built from full-width arithmetic and operand signs
  function automatic logic [17:0] model(logic [15:0] a, logic [15:0] b, logic ci, logic sub);
    logic [16:0] f;
    logic ov;
    f = sub ? {1'b0, a} + {1'b0, ~b} + {16'b0, ~ci} : {1'b0, a} + {1'b0, b} + {16'b0, ci};
    ov = sub ? (a[15] != b[15] && f[15] != a[15]) : (a[15] == b[15] && f[15] != a[15]);
    return {f[16], ov, f[15:0]};
  endfunction

  task automatic drive(logic [15:0] a, logic [15:0] b, logic ci, logic sub);
    if1.A = a; if4.A = a; if16.A = a;
    if1.B = b; if4.B = b; if16.B = b;
    if1.CI = ci; if4.CI = ci; if16.CI = ci;
    if1.sub = sub; if4.sub = sub; if16.sub = sub;
  endtask

  task automatic issue(logic [2:0] m, logic [15:0] a, logic [15:0] b, logic ci, logic sub, logic [17:0] e);
    drive(a, b, ci, sub);
    if1.start = m[0]; if4.start = m[1]; if16.start = m[2];
    if (m[0]) q1.push_back(e);
    if (m[1]) q4.push_back(e);
    if (m[2]) q16.push_back(e);
    @(negedge clk);
    if1.start = 1'b0; if4.start = 1'b0; if16.start = 1'b0;
  endtask

  task automatic wait_all();
    for (int i = 0; i < 40 && (q1.size() + q4.size() + q16.size()) != 0; i++) @(negedge clk);
    chk("pending_results", q1.size() + q4.size() + q16.size(), 0);
    @(negedge clk);
  endtask

  always @(negedge clk) if (!rst && if1.done) begin
    if (q1.size() == 0) chk("d1_spurious_done", 1, 0);
    else chk("d1_result", {if1.CO, if1.OV, if1.S}, q1.pop_front());
  end
  always @(negedge clk) if (!rst && if4.done) begin
    if (q4.size() == 0) chk("d4_spurious_done", 1, 0);
    else chk("d4_result", {if4.CO, if4.OV, if4.S}, q4.pop_front());
  end
  always @(negedge clk) if (!rst && if16.done) begin
    if (q16.size() == 0) chk("d16_spurious_done", 1, 0);
    else chk("d16_result", {if16.CO, if16.OV, if16.S}, q16.pop_front());
  end

  logic [15:0] va[7] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0000, 16'h0005, 16'h8000, 16'h0010};
  logic [15:0] vb[7] = '{16'h4321, 16'h0001, 16'h0001, 16'h0000, 16'h0007, 16'h0001, 16'h0001};
  logic vc[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic vs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [17:0] ve[7] = '{18'h05555, 18'h20000, 18'h18000, 18'h00001, 18'h0FFFE, 18'h37FFF, 18'h2000E};

  initial begin
    int cnt;
    logic [15:0] ra, rb;
    logic rc, rs;
    if1.start = 1'b0; if4.start = 1'b0; if16.start = 1'b0;
    drive(16'h0, 16'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_state_d1", {if1.busy, if1.done, if1.CO, if1.OV, if1.S}, 0);
    chk("rst_state_d4", {if4.busy, if4.done, if4.CO, if4.OV, if4.S}, 0);
    chk("rst_state_d16", {if16.busy, if16.done, if16.CO, if16.OV, if16.S}, 0);
    rst = 1'b0;
    @(negedge clk);
    issue(3'b010, 16'h1234, 16'h4321, 1'b0, 1'b0, 18'h05555);
    cnt = 0;
    for (int i = 0; i < 20 && !if4.done; i++) begin
      if (if4.busy) cnt++;
      @(negedge clk);
    end
    chk("busy_cycles", cnt, 4);
    chk("done_seen", {31'b0, if4.done}, 1);
    @(negedge clk);
    chk("done_single_pulse", {31'b0, if4.done}, 0);
    for (int k = 0; k < 7; k++) begin
      issue(3'b111, va[k], vb[k], vc[k], vs[k], ve[k]);
      wait_all();
    end
    // start while busy must be ignored and operand changes must not leak in
    issue(3'b010, 16'h1234, 16'h4321, 1'b0, 1'b0, 18'h05555);
    if4.start = 1'b1;
    drive(16'hAAAA, 16'h5555, 1'b1, 1'b1);
    @(negedge clk);
    if4.start = 1'b0;
    drive(16'h0F0F, 16'hF0F0, 1'b1, 1'b1);
    for (int i = 0; i < 20 && !if4.done; i++) @(negedge clk);
    chk("ignore_done_seen", {31'b0, if4.done}, 1);
    issue(3'b010, 16'h0001, 16'h0001, 1'b0, 1'b0, 18'h00002);
    cnt = 1;
    for (int i = 0; i < 20 && !if4.done; i++) begin
      @(negedge clk);
      cnt++;
    end
    chk("b2b_gap", cnt, 5);
    wait_all();
    drive(16'h1234, 16'h4321, 1'b0, 1'b0);
    if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("rst_async", {if4.busy, if4.done, if4.CO, if4.OV, if4.S}, 0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (if4.done) cnt++;
    end
    chk("rst_no_done", cnt, 0);
    issue(3'b010, 16'h1234, 16'h4321, 1'b0, 1'b0, 18'h05555);
    wait_all();
    for (int k = 0; k < 1000; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      issue(3'b111, ra, rb, rc, rs, model(ra, rb, rc, rs));
      wait_all();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multicycle_adder_subtractor.md
Name: multicycle_adder_subtractor

Overview:
- Parametrised successor to the team's single-bit full adder.
- Performs WIDTH-bit add or subtract over several clock cycles, DIGIT bits per cycle, chaining the carry through a register between cycles.
- Uses a start/busy/done handshake and signed-overflow detection.
- Sits in the datapath as the area-lean ALU adder; DIGIT trades area for latency.

Parameters:
- WIDTH, 16, operand/result width in bits; must be an integer multiple of DIGIT.
- DIGIT, 4, bits summed per cycle (1 = pure bit-serial; WIDTH = single-cycle ripple).
- Derived: N = WIDTH/DIGIT RUN cycles per operation.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on rising clk.
- sub  input  1  0 = add, 1 = subtract; latched with operands.
- A  input  WIDTH  operand A; latched on accepted start.
- B  input  WIDTH  operand B; latched on accepted start.
- CI  input  1  carry-in (add) or borrow-in (sub); latched on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when a result is written.
- S  output  WIDTH  result, registered and held.
- CO  output  1  carry-out (add) or not-borrow (sub), held.
- OV  output  1  two's-complement signed overflow, held.

Behaviour:
- Reset: asynchronous, active-high, exactly one clock (clk); no other clock domain. While rst is high: state = IDLE and busy = done = 0. S, CO, OV, the digit counter, the carry register and the operand registers are all 0.
- States: IDLE, RUN, DONE.
  - IDLE, start = 1: latch A, B ^ {WIDTH{sub}}, carry register = CI ^ sub, counter = 0, go to RUN.
  - IDLE, start = 0: stay in IDLE.
  - RUN, each edge: sum digit k = counter, meaning bits [k*DIGIT +: DIGIT] of A_reg, B_reg and the carry register. Store the sum bits in the internal result shift register. Update the carry register to the digit's carry-out. Increment the counter.
  - RUN, edge that processes digit N-1: write S, CO and OV; done = 1 in the following cycle; go to DONE.
  - DONE, start = 1: accept a new operation exactly as in IDLE (back-to-back allowed). done drops.
  - DONE, start = 0: go to IDLE; done drops.
- Arithmetic: S = A + B + CI (add) or A - B - CI (sub), modulo 2^WIDTH.
  - CO is the carry out of the MSB.
  - OV = carry into MSB XOR carry out of MSB.
- Latency:
  - The start-accept edge is e0; digits are processed on edges e1 to eN.
  - busy is high from e0 to eN.
  - done is high for exactly the single cycle between eN and eN+1.
  - Throughput: one result per N+1 cycles.
- Handshake: start while busy = 1 is ignored; no queuing, latched operands are unaffected. A, B, sub and CI may change freely after the accept edge.
- Outputs: S, CO and OV change only on the completion edge, and hold until the next completion or reset. Partial sums are never visible on S.
- Reset mid-operation: the operation is abandoned, all outputs are forced to reset values immediately, and no done pulse is produced.
- DIGIT = WIDTH: N = 1, so done follows one RUN cycle. DIGIT = 1: N = WIDTH.

Test Plan:
- WIDTH=16, DIGIT=4, add 0x1234 + 0x4321, CI=0 -> S=0x5555, CO=0, OV=0. busy high for 4 cycles; done is a single pulse in the cycle after the 4th RUN edge.
- Add 0xFFFF + 0x0001 -> S=0x0000, CO=1, OV=0. Add 0x7FFF + 0x0001 -> S=0x8000, CO=0, OV=1. Add 0x0000 + 0x0000 with CI=1 -> S=0x0001.
- Sub 0x0005 - 0x0007 -> S=0xFFFE, CO=0, OV=0. Sub 0x8000 - 0x0001 -> S=0x7FFF, CO=1, OV=1. Sub 0x0010 - 0x0001 with CI=1 -> S=0x000E, CO=1.
- During busy: pulse start with A=0xAAAA and change A/B to other values. Required: both ignored; the original result is returned. Then hold start high in the DONE cycle with A=0x0001, B=0x0001 -> second op accepted, S=0x0002 exactly N+1 cycles after the first done.
- Assert rst at the 2nd RUN edge of 0x1234 + 0x4321. Required: busy, done, S, CO and OV go to 0 asynchronously; no done pulse after release; the next start completes normally.
- Re-run the first three scenarios with DIGIT=1 (16 RUN cycles) and DIGIT=16 (1 RUN cycle). Results must match a reference model over 1000 random A/B/CI/sub vectors per configuration.
